// File: rtl/hasti_pkg.sv
// Shared AHB-Lite (Hasti) encodings and the default-slave error FSM state type.
package hasti_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_ERR1 = 2'd1,
    ERR_ERR2 = 2'd2
  } err_state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no data phase.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/hasti_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ accesses with the two-cycle AHB ERROR response.
module hasti_default_slave
  import hasti_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic       unmapped,
  output logic       err_hready,
  output logic       err_hresp,
  output err_state_e state
);

  err_state_e state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ERR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_hready = 1'b1;
    err_hresp  = HRESP_OKAY;
    case (state)
      ERR_IDLE: begin
        if (hready && unmapped) state_next = ERR_ERR1;
      end
      ERR_ERR1: begin
        err_hready = 1'b0;
        err_hresp  = HRESP_ERROR;
        state_next = ERR_ERR2;
      end
      ERR_ERR2: begin
        err_hresp  = HRESP_ERROR;
        // hready is high here, so a pending unmapped address phase is accepted now.
        state_next = (hready && unmapped) ? ERR_ERR1 : ERR_IDLE;
      end
      default: state_next = ERR_IDLE;
    endcase
  end

endmodule

// File: rtl/hasti_bus_xbar.sv
// Single-master to NSLAVES AHB-Lite decoder/mux with lowest-index priority,
// registered data-phase ownership and a built-in error slave for unmapped space.
module hasti_bus_xbar
  import hasti_pkg::*;
#(
  parameter int NSLAVES = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter logic [NSLAVES*ADDR_W-1:0] BASE = {32'hF000_0000, 32'h0000_0000, 32'h2000_0000},
  parameter logic [NSLAVES*ADDR_W-1:0] MASK = {3{32'hF000_0000}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           m_haddr,
  input  logic                        m_hwrite,
  input  logic [2:0]                  m_hsize,
  input  logic [2:0]                  m_hburst,
  input  logic [3:0]                  m_hprot,
  input  logic [1:0]                  m_htrans,
  input  logic                        m_hmastlock,
  input  logic [DATA_W-1:0]           m_hwdata,
  output logic [DATA_W-1:0]           m_hrdata,
  output logic                        m_hready,
  output logic                        m_hresp,
  output logic [ADDR_W-1:0]           s_haddr,
  output logic                        s_hwrite,
  output logic [2:0]                  s_hsize,
  output logic [2:0]                  s_hburst,
  output logic [3:0]                  s_hprot,
  output logic [1:0]                  s_htrans,
  output logic                        s_hmastlock,
  output logic [DATA_W-1:0]           s_hwdata,
  output logic [NSLAVES-1:0]          s_hsel,
  output logic                        s_hreadyin,
  input  logic [NSLAVES*DATA_W-1:0]   s_hrdata,
  input  logic [NSLAVES-1:0]          s_hreadyout,
  input  logic [NSLAVES-1:0]          s_hresp,
  output err_state_e                  dbg_err_state
);

  if (NSLAVES < 1 || NSLAVES > 16) begin : g_bad_nslaves
    $fatal(1, "hasti_bus_xbar: NSLAVES must be in 1..16");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $fatal(1, "hasti_bus_xbar: DATA_W must be 32 or 64");
  end

  // Handshake: a transfer's address phase is accepted on the rising edge where
  // m_hready is high; its data phase ends on the next edge where m_hready is high.
  logic [NSLAVES-1:0] hit;
  logic [NSLAVES-1:0] sel;
  logic               sel_found;
  logic               unmapped;
  logic [NSLAVES:0]   dsel;
  logic               err_hready;
  logic               err_hresp;

  assign s_haddr     = m_haddr;
  assign s_hwrite    = m_hwrite;
  assign s_hsize     = m_hsize;
  assign s_hburst    = m_hburst;
  assign s_hprot     = m_hprot;
  assign s_htrans    = m_htrans;
  assign s_hmastlock = m_hmastlock;
  assign s_hwdata    = m_hwdata;
  assign s_hreadyin  = m_hready;
  assign s_hsel      = sel;

  for (genvar g = 0; g < NSLAVES; g++) begin : g_dec
    logic [ADDR_W-1:0] base_g;
    logic [ADDR_W-1:0] mask_g;
    assign base_g = BASE[g*ADDR_W +: ADDR_W];
    assign mask_g = MASK[g*ADDR_W +: ADDR_W];
    assign hit[g] = ((m_haddr & mask_g) == (base_g & mask_g));
  end

  // Overlapping regions resolve to the lowest slave index.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (hit[k] && !sel_found) begin
        sel[k]    = 1'b1;
        sel_found = 1'b1;
      end
    end
  end

  assign unmapped = htrans_active(m_htrans) && !(|hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsel <= '0;
    end else if (m_hready) begin
      dsel <= {unmapped, sel};
    end
  end

  hasti_default_slave u_default_slave (
    .clk        (clk),
    .rst_n      (rst_n),
    .hready     (m_hready),
    .unmapped   (unmapped),
    .err_hready (err_hready),
    .err_hresp  (err_hresp),
    .state      (dbg_err_state)
  );

  // Response path depends only on registered ownership, never on the live decode.
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = HRESP_OKAY;
    m_hrdata = '0;
    if (dsel[NSLAVES]) begin
      m_hready = err_hready;
      m_hresp  = err_hresp;
    end
    for (int k = 0; k < NSLAVES; k++) begin
      if (dsel[k]) begin
        m_hready = s_hreadyout[k];
        m_hresp  = s_hresp[k];
        m_hrdata = s_hrdata[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_hasti_bus_xbar.sv
// Randomized scoreboard bench for hasti_bus_xbar: a 4-slave map with an overlapping
// pair, bench-modelled slaves with random wait states, and a directed async reset case.
module tb_hasti_bus_xbar;
  import hasti_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  // slave0 0x0xxx_xxxx, slave1 0x0000_0000..0x1FFF_FFFF (overlaps slave0),
  // slave2 0x2xxx_xxxx, slave3 0xFxxx_xxxx
  localparam logic [AW-1:0] REG_BASE [NS] = '{32'h0000_0000, 32'h0000_0000, 32'h2000_0000, 32'hF000_0000};
  localparam logic [AW-1:0] REG_MASK [NS] = '{32'hF000_0000, 32'hE000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [NS*AW-1:0] P_BASE = {32'hF000_0000, 32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] P_MASK = {32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hF000_0000};

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     m_haddr;
  logic              m_hwrite;
  logic [2:0]        m_hsize;
  logic [2:0]        m_hburst;
  logic [3:0]        m_hprot;
  logic [1:0]        m_htrans;
  logic              m_hmastlock;
  logic [DW-1:0]     m_hwdata;
  logic [DW-1:0]     m_hrdata;
  logic              m_hready;
  logic              m_hresp;
  logic [AW-1:0]     s_haddr;
  logic              s_hwrite;
  logic [2:0]        s_hsize;
  logic [2:0]        s_hburst;
  logic [3:0]        s_hprot;
  logic [1:0]        s_htrans;
  logic              s_hmastlock;
  logic [DW-1:0]     s_hwdata;
  logic [NS-1:0]     s_hsel;
  logic              s_hreadyin;
  logic [NS*DW-1:0]  s_hrdata;
  logic [NS-1:0]     s_hreadyout;
  logic [NS-1:0]     s_hresp;
  err_state_e        dbg_err_state;

  hasti_bus_xbar #(
    .NSLAVES (NS),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .BASE    (P_BASE),
    .MASK    (P_MASK)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_haddr       (m_haddr),
    .m_hwrite      (m_hwrite),
    .m_hsize       (m_hsize),
    .m_hburst      (m_hburst),
    .m_hprot       (m_hprot),
    .m_htrans      (m_htrans),
    .m_hmastlock   (m_hmastlock),
    .m_hwdata      (m_hwdata),
    .m_hrdata      (m_hrdata),
    .m_hready      (m_hready),
    .m_hresp       (m_hresp),
    .s_haddr       (s_haddr),
    .s_hwrite      (s_hwrite),
    .s_hsize       (s_hsize),
    .s_hburst      (s_hburst),
    .s_hprot       (s_hprot),
    .s_htrans      (s_htrans),
    .s_hmastlock   (s_hmastlock),
    .s_hwdata      (s_hwdata),
    .s_hsel        (s_hsel),
    .s_hreadyin    (s_hreadyin),
    .s_hrdata      (s_hrdata),
    .s_hreadyout   (s_hreadyout),
    .s_hresp       (s_hresp),
    .dbg_err_state (dbg_err_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          resp;
    logic [3:0]    waits;
    logic          write;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  // bench-side slave model state
  int            cur_owner = -1;   // -1 none, 0..NS-1 slave, NS default slave
  int            cur_wait  = 0;
  logic [DW-1:0] cur_rdata = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [AW-1:0] ap_addr;
  logic [1:0]    ap_trans;
  logic          ap_write;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode: each region is the address range [base&mask, base|~mask].
  function automatic int model_target(input logic [AW-1:0] a);
    logic [AW-1:0] lo;
    logic [AW-1:0] hi;
    for (int i = 0; i < NS; i++) begin
      lo = REG_BASE[i] & REG_MASK[i];
      hi = lo | ~REG_MASK[i];
      if (a >= lo && a <= hi) return i;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] model_hsel(input logic [AW-1:0] a);
    int t;
    logic [NS-1:0] v;
    t = model_target(a);
    v = '0;
    if (t >= 0) v[t] = 1'b1;
    return v;
  endfunction

  task automatic new_ap(input bit force_idle);
    int kind;
    int tr;
    kind = $urandom_range(0, 5);
    case (kind)
      0: ap_addr = 32'h0000_0000 | ($urandom & 32'h0FFF_FFFC);
      1: ap_addr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      2: ap_addr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
      3: ap_addr = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
      4: ap_addr = 32'h5000_0000 | ($urandom & 32'h0FFF_FFFC);
      default: ap_addr = 32'hA000_0000 | ($urandom & 32'h0FFF_FFFC);
    endcase
    tr = $urandom_range(0, 9);
    if (force_idle || tr < 2) ap_trans = HTRANS_IDLE;
    else if (tr == 2)         ap_trans = HTRANS_BUSY;
    else if (tr < 7)          ap_trans = HTRANS_NONSEQ;
    else                      ap_trans = HTRANS_SEQ;
    ap_write = 1'($urandom_range(0, 1));
  endtask

  // Owner slave answers from the model; the others drive noise the mux must ignore.
  task automatic drive_slaves();
    for (int i = 0; i < NS; i++) begin
      if (i == cur_owner) begin
        s_hreadyout[i]        = (cur_wait == 0);
        s_hresp[i]            = HRESP_OKAY;
        s_hrdata[i*DW +: DW]  = cur_rdata;
      end else begin
        s_hreadyout[i]        = 1'($urandom_range(0, 1));
        s_hresp[i]            = 1'($urandom_range(0, 1));
        s_hrdata[i*DW +: DW]  = $urandom;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit   dp;
    int   wc;
    exp_t e;
    dp = 1'b0;
    wc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        dp = 1'b0;
        wc = 0;
      end else begin
        if (dp) begin
          if (exp_q.size() == 0) begin
            check("exp_queue_nonempty", 64'(exp_q.size()), 64'd1);
            dp = 1'b0;
          end else if (!m_hready) begin
            e = exp_q[0];
            wc++;
            check("wait_hresp", 64'(m_hresp), 64'(e.resp));
            if (e.write) check("wait_hwdata", 64'(s_hwdata), 64'(e.wdata));
            if (wc > 16) begin
              check("data_phase_timeout", 64'(wc), 64'(e.waits));
              void'(exp_q.pop_front());
              dp = 1'b0;
              wc = 0;
            end
          end else begin
            e = exp_q.pop_front();
            check("hrdata", 64'(m_hrdata), 64'(e.rdata));
            check("hresp", 64'(m_hresp), 64'(e.resp));
            check("wait_cycles", 64'(wc), 64'(e.waits));
            if (e.write) check("hwdata", 64'(s_hwdata), 64'(e.wdata));
            wc = 0;
          end
        end else begin
          check("idle_hready", 64'(m_hready), 64'd1);
          check("idle_hresp", 64'(m_hresp), 64'd0);
        end
        if (m_hready) dp = m_htrans[1];
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [AW-1:0] sel_addr [4] = '{32'h0000_0004, 32'h1000_0000, 32'h2000_0010, 32'h5000_0000};

  initial begin : main
    logic hr;
    int   tgt;
    exp_t e;

    rst_n       = 1'b0;
    m_haddr     = '0;
    m_hwrite    = 1'b0;
    m_hsize     = HSIZE_WORD;
    m_hburst    = 3'd0;
    m_hprot     = 4'h3;
    m_htrans    = HTRANS_IDLE;
    m_hmastlock = 1'b0;
    m_hwdata    = '0;
    s_hrdata    = '0;
    s_hreadyout = '1;
    s_hresp     = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hready", 64'(m_hready), 64'd1);
    check("reset_hresp", 64'(m_hresp), 64'd0);
    check("reset_hrdata", 64'(m_hrdata), 64'd0);
    check("reset_fsm", 64'(dbg_err_state), 64'(ERR_IDLE));
    rst_n = 1'b1;

    // decode table incl. overlap (slave0 and slave1 both cover 0x0000_0004)
    for (int i = 0; i < 4; i++) begin
      m_haddr = sel_addr[i];
      #1;
      check("hsel_decode", 64'(s_hsel), 64'(model_hsel(sel_addr[i])));
    end
    m_haddr = 32'h5000_0000;
    @(posedge clk);
    @(posedge clk);
    #1;

    // randomized traffic
    mon_en    = 1'b1;
    cur_owner = -1;
    new_ap(1'b0);
    for (int c = 0; c < 1500; c++) begin
      m_haddr  = ap_addr;
      m_htrans = ap_trans;
      m_hwrite = ap_write;
      m_hwdata = cur_wdata;
      drive_slaves();
      @(negedge clk);
      check("hsel", 64'(s_hsel), 64'(model_hsel(ap_addr)));
      hr = m_hready;
      @(posedge clk);
      #1;
      if (hr) begin
        tgt       = model_target(ap_addr);
        cur_rdata = $urandom;
        cur_wdata = $urandom;
        if (ap_trans[1]) begin
          if (tgt >= 0) begin
            cur_owner = tgt;
            cur_wait  = $urandom_range(0, 3);
            e = '{rdata: cur_rdata, resp: HRESP_OKAY, waits: 4'(cur_wait), write: ap_write, wdata: cur_wdata};
          end else begin
            cur_owner = NS;
            cur_wait  = 1;
            e = '{rdata: '0, resp: HRESP_ERROR, waits: 4'd1, write: ap_write, wdata: cur_wdata};
          end
          exp_q.push_back(e);
        end else begin
          cur_owner = tgt;
          cur_wait  = 0;
        end
        new_ap(c > 1480);
      end else if (cur_owner >= 0 && cur_owner < NS && cur_wait > 0) begin
        cur_wait--;
      end
    end
    m_htrans = HTRANS_IDLE;
    drive_slaves();
    @(negedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    // directed: slave1 read, then slave0 write address while slave1 stalls, reset mid data phase
    s_hreadyout = '1;
    s_hresp     = '0;
    m_haddr     = 32'h1000_0000;
    m_htrans    = HTRANS_NONSEQ;
    m_hwrite    = 1'b0;
    s_hrdata[1*DW +: DW] = 32'hCAFE_F00D;
    @(negedge clk);
    check("b2b_hsel_s1", 64'(s_hsel), 64'b0010);
    @(posedge clk);
    #1;
    m_haddr        = 32'h0000_0040;
    m_hwrite       = 1'b1;
    m_hwdata       = 32'h1234_5678;
    s_hreadyout[1] = 1'b0;
    @(negedge clk);
    check("b2b_hready_stall", 64'(m_hready), 64'd0);
    check("b2b_hrdata_s1", 64'(m_hrdata), 64'hCAFE_F00D);
    check("b2b_hsel_s0", 64'(s_hsel), 64'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hready", 64'(m_hready), 64'd1);
    check("rst_hresp", 64'(m_hresp), 64'd0);
    check("rst_hrdata", 64'(m_hrdata), 64'd0);
    @(posedge clk);
    #1;
    check("rst_hold_hready", 64'(m_hready), 64'd1);
    m_htrans = HTRANS_IDLE;
    m_haddr  = 32'h5000_0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_unmapped_hready", 64'(m_hready), 64'd1);
    check("idle_unmapped_hresp", 64'(m_hresp), 64'd0);
    check("idle_unmapped_fsm", 64'(dbg_err_state), 64'(ERR_IDLE));
    @(posedge clk);
    #1;
    check("idle_unmapped_hready2", 64'(m_hready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
